imem_loader: RTL

Sequential writer for the instruction memory. Accepts a byte stream over a valid/ready handshake, packs four little-endian bytes into each 32-bit instruction word and issues one-cycle write strobes to the instruction memory's write port. It holds the core in reset for the whole load, so the single-cycle RISC-V core only fetches a complete program.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 33 +++
 rtl/imem_loader.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encoding and word/byte geometry.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_CHK   = 3'd4
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Little-endian byte-to-word packer: each enabled byte lands in lane [index], index wraps per word.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clr,
    input  logic                        i_byte_en,
    input  logic [7:0]                  i_byte,
    output logic [8*BYTES_PER_WORD-1:0] o_word,
    output logic                        o_word_full
);

    logic [BYTES_PER_WORD-1:0][7:0] r_lanes;
    logic [IDX_W-1:0]               r_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lanes <= '0;
            r_idx   <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_byte_en) begin
            r_lanes[r_idx] <= i_byte;
            r_idx          <= r_idx + IDX_W'(1);
        end
    end

    // Asserted in the cycle the last lane is being accepted, so the FSM can move to WRITE.
    assign o_word_full = i_byte_en && (r_idx == IDX_W'(BYTES_PER_WORD - 1));
    assign o_word      = r_lanes;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory; holds the core in reset while loading.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_s_ready;
    logic              r_mem_we;
    logic              r_busy;
    logic              r_done;

    logic              w_start_ok;
    logic [ADDR_W:0]   w_cnt_sat;
    logic              w_acc;
    logic              w_word_full;
    logic [DATA_W-1:0] w_word;

    assign w_start_ok = (r_state == S_IDLE) && start && (num_words != '0);
    assign w_cnt_sat  = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign w_acc      = s_valid && r_s_ready;

    word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_start_ok),
        .i_byte_en   (w_acc && (r_state == S_RECV)),
        .i_byte      (s_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_mem_we  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor     <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start_ok) begin
                    r_addr    <= base_addr;
                    r_cnt     <= w_cnt_sat;
                    r_s_ready <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= S_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_xor     <= '0;
                    r_err     <= 1'b0;
`endif
                end
                S_RECV: if (w_acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    r_xor <= r_xor ^ s_data;
`endif
                    if (w_word_full) begin
                        r_s_ready <= 1'b0;
                        r_mem_we  <= 1'b1;
                        r_state   <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_addr <= r_addr + ADDR_W'(1);
                    r_cnt  <= r_cnt - (ADDR_W+1)'(1);
                    if (r_cnt != (ADDR_W+1)'(1)) begin
                        r_s_ready <= 1'b1;
                        r_state   <= S_RECV;
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_s_ready <= 1'b1;
                        r_state   <= S_CHK;
`else
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: if (w_acc) begin
                    r_err     <= (s_data != r_xor);
                    r_s_ready <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_DONE;
                end
`endif
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_s_ready <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign mem_we    = r_mem_we;
    assign mem_waddr = r_addr;
    assign mem_wdata = w_word;
    assign busy      = r_busy;
    assign cpu_hold  = r_busy;
    assign done      = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err       = r_err;
`else
    assign err       = 1'b0;
`endif

endmodule
